// File: rtl/chronometer_lap_counter_pkg.sv
// Shared definitions for the chronometer counting core: FSM encoding,
// digit moduli, display field layout and the BCD time payload.
package chronometer_lap_counter_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DIGITS_W   = DIGIT_W * NUM_DIGITS;
    localparam int unsigned STATE_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_e;

    // Moduli for the fixed-range digits; minutes-tens is parameterised in the top.
    localparam int unsigned MOD_CEN_U = 10;
    localparam int unsigned MOD_CEN_T = 10;
    localparam int unsigned MOD_SEC_U = 10;
    localparam int unsigned MOD_SEC_T = 6;
    localparam int unsigned MOD_MIN_U = 10;

    localparam int unsigned OFS_CEN_U = 0;
    localparam int unsigned OFS_CEN_T = 4;
    localparam int unsigned OFS_SEC_U = 8;
    localparam int unsigned OFS_SEC_T = 12;
    localparam int unsigned OFS_MIN_U = 16;
    localparam int unsigned OFS_MIN_T = 20;

    typedef struct packed {
        logic [DIGIT_W-1:0] min_t;
        logic [DIGIT_W-1:0] min_u;
        logic [DIGIT_W-1:0] sec_t;
        logic [DIGIT_W-1:0] sec_u;
        logic [DIGIT_W-1:0] cen_t;
        logic [DIGIT_W-1:0] cen_u;
    } bcd_time_t;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the chronometer carry chain; counts 0..MODULUS-1.
module bcd_digit_counter
    import chronometer_lap_counter_pkg::*;
#(
    parameter int unsigned MODULUS = 10
) (
    input  logic               clk_ms,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    localparam logic [DIGIT_W-1:0] LAST = DIGIT_W'(MODULUS - 1);

    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;

    // Rolling over on >= LAST keeps the digit inside its modulus even from a bad value.
    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = '0;
        end else if (inc) begin
            q_d = (q_q >= LAST) ? '0 : q_q + DIGIT_W'(1);
        end
    end

    always_ff @(posedge clk_ms or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc && (q_q == LAST);

endmodule

// File: rtl/chronometer_lap_counter.sv
// Start/stop chronometer core: command FSM, 100 Hz tick recovery,
// six-digit BCD count chain and lap freeze register.
module chronometer_lap_counter
    import chronometer_lap_counter_pkg::*;
#(
    parameter int unsigned MAX_MIN_TENS = 5
) (
    input  logic                clk_ms,
    input  logic                rst_n,
    input  logic                clk_sl,
    input  logic                start_stop,
    input  logic                reset_cmd,
    input  logic                lap,
    output logic [DIGITS_W-1:0] digits,
    output logic                running,
    output logic                lap_active,
    output logic                wrap
);

    state_e state_q;
    state_e state_d;

    logic sync1_q;
    logic sync2_q;
    logic sl_prev_q;
    logic tick_c;
    logic count_en_c;
    logic clear_c;

    bcd_time_t live_c;
    bcd_time_t lap_q;
    bcd_time_t lap_d;
    logic      lap_active_q;
    logic      lap_active_d;
    logic      running_q;
    logic      running_d;
    logic      wrap_q;
    logic      wrap_d;

    logic [DIGIT_W-1:0] q_cen_u;
    logic [DIGIT_W-1:0] q_cen_t;
    logic [DIGIT_W-1:0] q_sec_u;
    logic [DIGIT_W-1:0] q_sec_t;
    logic [DIGIT_W-1:0] q_min_u;
    logic [DIGIT_W-1:0] q_min_t;
    logic               carry_cen_u;
    logic               carry_cen_t;
    logic               carry_sec_u;
    logic               carry_sec_t;
    logic               carry_min_u;
    logic               carry_min_t;

    // Slow clock resynchronisation and rising-edge tick.
    always_ff @(posedge clk_ms or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sl_prev_q <= 1'b0;
        end else begin
            sync1_q   <= clk_sl;
            sync2_q   <= sync1_q;
            sl_prev_q <= sync2_q;
        end
    end

    assign tick_c     = sync2_q && !sl_prev_q;
    assign count_en_c = tick_c && (state_q == ST_RUNNING);

    always_ff @(posedge clk_ms or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // reset_cmd wins arbitration even when it is ignored in RUNNING.
    always_comb begin
        state_d = state_q;
        clear_c = 1'b0;
        if (reset_cmd) begin
            if (state_q != ST_RUNNING) begin
                state_d = ST_IDLE;
                clear_c = 1'b1;
            end
        end else if (start_stop) begin
            case (state_q)
                ST_IDLE:    state_d = ST_RUNNING;
                ST_RUNNING: state_d = ST_PAUSED;
                ST_PAUSED:  state_d = ST_RUNNING;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Lap snapshot takes the pre-increment live value.
    always_comb begin
        lap_active_d = lap_active_q;
        lap_d        = lap_q;
        if (clear_c) begin
            lap_active_d = 1'b0;
            lap_d        = '0;
        end else if (!reset_cmd && !start_stop && lap) begin
            if (lap_active_q) begin
                lap_active_d = 1'b0;
            end else if (state_q == ST_RUNNING) begin
                lap_active_d = 1'b1;
                lap_d        = live_c;
            end
        end
        running_d = (state_d == ST_RUNNING);
        wrap_d    = carry_min_t;
    end

    always_ff @(posedge clk_ms or negedge rst_n) begin
        if (!rst_n) begin
            lap_q        <= '0;
            lap_active_q <= 1'b0;
            running_q    <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            lap_q        <= lap_d;
            lap_active_q <= lap_active_d;
            running_q    <= running_d;
            wrap_q       <= wrap_d;
        end
    end

    bcd_digit_counter #(.MODULUS(MOD_CEN_U)) u_cen_u (
        .clk_ms (clk_ms),
        .rst_n  (rst_n),
        .clear  (clear_c),
        .inc    (count_en_c),
        .q      (q_cen_u),
        .carry  (carry_cen_u)
    );

    bcd_digit_counter #(.MODULUS(MOD_CEN_T)) u_cen_t (
        .clk_ms (clk_ms),
        .rst_n  (rst_n),
        .clear  (clear_c),
        .inc    (carry_cen_u),
        .q      (q_cen_t),
        .carry  (carry_cen_t)
    );

    bcd_digit_counter #(.MODULUS(MOD_SEC_U)) u_sec_u (
        .clk_ms (clk_ms),
        .rst_n  (rst_n),
        .clear  (clear_c),
        .inc    (carry_cen_t),
        .q      (q_sec_u),
        .carry  (carry_sec_u)
    );

    bcd_digit_counter #(.MODULUS(MOD_SEC_T)) u_sec_t (
        .clk_ms (clk_ms),
        .rst_n  (rst_n),
        .clear  (clear_c),
        .inc    (carry_sec_u),
        .q      (q_sec_t),
        .carry  (carry_sec_t)
    );

    bcd_digit_counter #(.MODULUS(MOD_MIN_U)) u_min_u (
        .clk_ms (clk_ms),
        .rst_n  (rst_n),
        .clear  (clear_c),
        .inc    (carry_sec_t),
        .q      (q_min_u),
        .carry  (carry_min_u)
    );

    bcd_digit_counter #(.MODULUS(MAX_MIN_TENS + 1)) u_min_t (
        .clk_ms (clk_ms),
        .rst_n  (rst_n),
        .clear  (clear_c),
        .inc    (carry_min_u),
        .q      (q_min_t),
        .carry  (carry_min_t)
    );

    assign live_c = '{min_t: q_min_t, min_u: q_min_u, sec_t: q_sec_t,
                      sec_u: q_sec_u, cen_t: q_cen_t, cen_u: q_cen_u};

    assign digits     = lap_active_q ? lap_q : live_c;
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_chronometer_lap_counter.sv
// Directed bench for the chronometer core: counting, pause, lap freeze,
// command priority, tick/command coincidence, rollover and async reset.
module tb_chronometer_lap_counter;

    logic        clk_ms     = 1'b0;
    logic        rst_n      = 1'b0;
    logic        clk_sl     = 1'b0;
    logic        start_stop = 1'b0;
    logic        reset_cmd  = 1'b0;
    logic        lap        = 1'b0;
    logic [23:0] digits;
    logic        running;
    logic        lap_active;
    logic        wrap;

    int total = 0;
    int bad   = 0;

    always #5 clk_ms = ~clk_ms;

    chronometer_lap_counter #(.MAX_MIN_TENS(5)) dut (
        .clk_ms     (clk_ms),
        .rst_n      (rst_n),
        .clk_sl     (clk_sl),
        .start_stop (start_stop),
        .reset_cmd  (reset_cmd),
        .lap        (lap),
        .digits     (digits),
        .running    (running),
        .lap_active (lap_active),
        .wrap       (wrap)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_ms);
        #1;
    endtask

    task automatic cmd(input logic ss, input logic rc, input logic lp);
        start_stop = ss;
        reset_cmd  = rc;
        lap        = lp;
        step();
        start_stop = 1'b0;
        reset_cmd  = 1'b0;
        lap        = 1'b0;
    endtask

    task automatic tick_rise();
        clk_sl = 1'b1;
        repeat (3) step();
    endtask

    task automatic tick_fall();
        clk_sl = 1'b0;
        repeat (2) step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_rise();
            tick_fall();
        end
    endtask

    initial begin
        // Reset values
        repeat (2) step();
        chk("rst_digits", digits, 24'h000000);
        chk("rst_running", 24'(running), 24'h0);
        chk("rst_lap_active", 24'(lap_active), 24'h0);
        chk("rst_wrap", 24'(wrap), 24'h0);
        rst_n = 1'b1;
        step();

        // Count 150 ticks, stop, then ticks are ignored
        cmd(1'b1, 1'b0, 1'b0);
        chk("start_running", 24'(running), 24'h1);
        ticks(150);
        chk("run150_digits", digits, 24'h000150);
        cmd(1'b1, 1'b0, 1'b0);
        chk("stop_running", 24'(running), 24'h0);
        ticks(20);
        chk("paused_hold", digits, 24'h000150);
        cmd(1'b0, 1'b1, 1'b0);
        chk("pause_reset_digits", digits, 24'h000000);

        // Lap freeze while live count continues
        cmd(1'b1, 1'b0, 1'b0);
        ticks(1234);
        chk("run1234_digits", digits, 24'h001234);
        cmd(1'b0, 1'b0, 1'b1);
        chk("lap_set", 24'(lap_active), 24'h1);
        ticks(100);
        chk("lap_frozen", digits, 24'h001234);
        cmd(1'b0, 1'b0, 1'b1);
        chk("lap_clear", 24'(lap_active), 24'h0);
        chk("lap_release_live", digits, 24'h001334);

        // reset_cmd ignored while running; reset after stop clears lap too
        cmd(1'b0, 1'b1, 1'b0);
        chk("run_reset_running", 24'(running), 24'h1);
        chk("run_reset_digits", digits, 24'h001334);
        ticks(1);
        chk("run_reset_counting", digits, 24'h001335);
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b1, 1'b0, 1'b0);
        chk("paused_lap_kept", 24'(lap_active), 24'h1);
        cmd(1'b0, 1'b1, 1'b0);
        chk("idle_reset_digits", digits, 24'h000000);
        chk("idle_reset_lap", 24'(lap_active), 24'h0);
        chk("idle_reset_running", 24'(running), 24'h0);
        cmd(1'b0, 1'b0, 1'b1);
        chk("idle_lap_ignored", 24'(lap_active), 24'h0);

        // reset_cmd beats start_stop from PAUSED
        cmd(1'b1, 1'b0, 1'b0);
        ticks(1);
        cmd(1'b1, 1'b0, 1'b0);
        chk("paused_one", digits, 24'h000001);
        cmd(1'b1, 1'b1, 1'b0);
        chk("prio_running", 24'(running), 24'h0);
        chk("prio_digits", digits, 24'h000000);

        // Tick coincident with start is dropped, with stop is counted
        clk_sl = 1'b1;
        repeat (2) step();
        cmd(1'b1, 1'b0, 1'b0);
        clk_sl = 1'b0;
        repeat (3) step();
        chk("tick_at_start_run", 24'(running), 24'h1);
        chk("tick_at_start_digits", digits, 24'h000000);
        clk_sl = 1'b1;
        repeat (2) step();
        cmd(1'b1, 1'b0, 1'b0);
        clk_sl = 1'b0;
        repeat (3) step();
        chk("tick_at_stop_run", 24'(running), 24'h0);
        chk("tick_at_stop_digits", digits, 24'h000001);

        // Preload 59:59.98 while paused, then roll over
        force dut.u_min_t.q_q = 4'd5;
        force dut.u_min_u.q_q = 4'd9;
        force dut.u_sec_t.q_q = 4'd5;
        force dut.u_sec_u.q_q = 4'd9;
        force dut.u_cen_t.q_q = 4'd9;
        force dut.u_cen_u.q_q = 4'd8;
        #1;
        release dut.u_min_t.q_q;
        release dut.u_min_u.q_q;
        release dut.u_sec_t.q_q;
        release dut.u_sec_u.q_q;
        release dut.u_cen_t.q_q;
        release dut.u_cen_u.q_q;
        step();
        chk("preload", digits, 24'h595998);
        cmd(1'b1, 1'b0, 1'b0);
        ticks(1);
        chk("max_digits", digits, 24'h595999);
        chk("max_no_wrap", 24'(wrap), 24'h0);
        tick_rise();
        chk("wrap_digits", digits, 24'h000000);
        chk("wrap_high", 24'(wrap), 24'h1);
        step();
        chk("wrap_one_cycle", 24'(wrap), 24'h0);
        tick_fall();
        ticks(1);
        chk("after_wrap_count", digits, 24'h000001);

        // Asynchronous reset mid-count with lap frozen
        cmd(1'b1, 1'b0, 1'b0);
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b1, 1'b0, 1'b0);
        ticks(500);
        chk("run500_digits", digits, 24'h000500);
        cmd(1'b0, 1'b0, 1'b1);
        ticks(3);
        chk("lap500_frozen", digits, 24'h000500);
        chk("lap500_active", 24'(lap_active), 24'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_digits", digits, 24'h000000);
        chk("async_rst_running", 24'(running), 24'h0);
        chk("async_rst_lap", 24'(lap_active), 24'h0);
        chk("async_rst_wrap", 24'(wrap), 24'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_running", 24'(running), 24'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
